stream_packer: RTL and testbench
================================

# stream_packer

Narrow-to-wide valid/ready stream packer: gathers RATIO consecutive IN_WIDTH beats into one OUT word, or fewer when `in_last` closes a short packet. It is the receive-side counterpart of our stream register/serializer path. It sits downstream of a narrow link and upstream of wide datapath logic. A registered spare-word stage lets `in_ready` come from a flop, so there is no combinational `out_ready` → `in_ready` path, and full throughput is kept while the downstream is ready.

## Interface
Parameters:
- `IN_WIDTH`, default 8: input beat width, ≥1.
- `RATIO`, default 4: beats per output word, ≥2.
- Derived, not overridable: `OUT_WIDTH = IN_WIDTH*RATIO`; `CW = $clog2(RATIO)`.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  IN_WIDTH  input beat.
- `in_last`  in  1  beat ends a packet and forces word emission.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  OUT_WIDTH  packed word; beat k is at bits [k*IN_WIDTH +: IN_WIDTH].
- `out_keep`  out  RATIO  bit k set when beat k is populated.
- `out_last`  out  1  word closes a packet.

## Operation
- Storage has three parts:
  - Accumulator: data, keep, last flag, beat counter `cnt` (CW bits).
  - Spare register: `acc_full`, holding one completed word.
  - Output register: drives `out_*`.
- `in_ready = !acc_full && !rst`. It is a registered term only.
- Accepted beat, not completing: write `in_data` into lane `cnt`, set `keep[cnt]`, then `cnt <= cnt+1`.
- Completing beat: `cnt == RATIO-1` or `in_last == 1`. The completed word is the accumulator plus this beat; its last flag = `in_last`. After completion `cnt` returns to 0 and accumulator keep clears.
- Where the completed word goes:
  - If `!out_valid || out_ready`, it loads the output register directly.
  - Otherwise it is held with `acc_full` set.
- While `acc_full` is set and `out_ready` is high, the held word moves to the output register and `acc_full` clears.
- Lanes not written in a short word read as 0 in `out_data`, with `out_keep` bits 0.
- Invariant: `acc_full == 1` implies `out_valid == 1`.
- Output register holds `out_data`, `out_keep` and `out_last` stable while `out_valid && !out_ready`.
- `in_last` on beat 0 emits a one-lane word with `out_keep = 'b0..01`.
- `in_data` and `in_last` are ignored when `in_valid` is 0 or `in_ready` is 0.

## Timing
- Reset, synchronous, takes effect at the edge where `rst=1`:
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`.
  - `cnt=0`, `acc_full=0`, accumulator cleared.
  - `in_ready` is 0 during reset and 1 in the first cycle after `rst` drops.
- Reset mid-packet discards the partial accumulator, the spare word and the output word. No word is emitted for them.
- Latency: completing beat accepted at edge t gives `out_valid=1` with that word after edge t, when the output path is free.
- Throughput: one beat per cycle sustained with `out_ready=1`. One word per RATIO cycles, with no bubbles at word boundaries.
- Backpressure:
  - Output stalled: the next word may still accumulate fully; `in_ready` stays 1.
  - After that word completes into the spare register, `in_ready` drops on the following cycle.
  - `in_ready` reasserts the cycle after the edge where `out_ready=1` drains the output word.
- Simultaneous events:
  - Output drain plus completing beat in the same cycle: the new word goes to the output register; `acc_full` stays 0.
  - Spare-to-output move plus drain in the same cycle is legal; the spare word appears the next cycle.

## Test plan
- Continuous stream, RATIO=4, IN_WIDTH=8: beats 0x11,0x22,0x33,0x44,0x55.. with `out_ready=1` → `out_data=0x44332211`, `out_keep=4'b1111`, `out_last=0` one cycle after beat 4; `in_ready` stays 1 throughout.
- Short packet: 0xA1,0xB2 with `in_last` on 0xB2 → `out_data=0x0000B2A1`, `out_keep=4'b0011`, `out_last=1`; next word starts in lane 0.
- Single-beat packet 0x5C with `in_last` → `out_data=0x0000005C`, `out_keep=4'b0001`, `out_last=1`.
- Backpressure: hold `out_ready=0` and send 12 beats → first word held stable, second word in the spare register, `in_ready=0` after beat 8. Release `out_ready` → words emerge in order, `in_ready` returns to 1, beats 9–12 form the third word; no loss or duplication.
- Reset mid-packet: two beats accepted, then `rst=1` for one cycle → `out_valid=0`, `out_keep=0`; the next 4 beats 0x01..0x04 produce exactly `0x04030201`.
- Random `in_valid` and `out_ready` (50%) over 1000 beats with random `in_last` → a scoreboard of reconstructed beats and packet boundaries matches the input.

Source files
------------

// File: rtl/stream_packer.sv
// stream_packer: narrow-to-wide valid/ready stream packer.
// Gathers RATIO consecutive IN_WIDTH beats into one output word, or fewer when
// in_last closes a short packet. A spare-word register sits behind the output
// register so in_ready depends only on a flop (plus reset), never on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    input beat (IN_WIDTH)
//   in_last    beat ends a packet, forces word emission
//   out_valid  output word valid
//   out_ready  downstream accepts the word
//   out_data   packed word, beat k at [k*IN_WIDTH +: IN_WIDTH]
//   out_keep   bit k set when beat k is populated
//   out_last   word closes a packet
module stream_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned CW        = $clog2(RATIO);

    // Accumulator
    logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]     acc_keep_q, acc_keep_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Spare word register
    logic                 acc_full_q, acc_full_d;
    logic [OUT_WIDTH-1:0] spare_data_q, spare_data_d;
    logic [RATIO-1:0]     spare_keep_q, spare_keep_d;
    logic                 spare_last_q, spare_last_d;

    // Output register
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;

    // Accumulator merged with the current beat
    logic [OUT_WIDTH-1:0] word_data;
    logic [RATIO-1:0]     word_keep;
    logic                 accept;
    logic                 complete;

    // in_ready comes from the spare-full flop only; reset forces it low
    assign in_ready  = !acc_full_q && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

    // Next-state logic for accumulator, spare and output registers
    always_comb begin
        acc_data_d   = acc_data_q;
        acc_keep_d   = acc_keep_q;
        cnt_d        = cnt_q;
        acc_full_d   = acc_full_q;
        spare_data_d = spare_data_q;
        spare_keep_d = spare_keep_q;
        spare_last_d = spare_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        word_data    = acc_data_q;
        word_keep    = acc_keep_q;

        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt_q == CW'(k)) begin
                word_data[k*IN_WIDTH +: IN_WIDTH] = in_data;
                word_keep[k]                      = 1'b1;
            end
        end

        accept   = in_valid && in_ready;
        complete = accept && (in_last || (cnt_q == CW'(RATIO - 1)));

        // Accumulator: clear lanes on completion so short words read 0 above the last lane
        if (accept) begin
            if (complete) begin
                acc_data_d = '0;
                acc_keep_d = '0;
                cnt_d      = '0;
            end else begin
                acc_data_d = word_data;
                acc_keep_d = word_keep;
                cnt_d      = cnt_q + CW'(1);
            end
        end

        // Word routing; no accept can happen while the spare is full
        if (acc_full_q) begin
            if (out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = spare_data_q;
                out_keep_d  = spare_keep_q;
                out_last_d  = spare_last_q;
                acc_full_d  = 1'b0;
            end
        end else if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = word_data;
                out_keep_d  = word_keep;
                out_last_d  = in_last;
            end else begin
                spare_data_d = word_data;
                spare_keep_d = word_keep;
                spare_last_d = in_last;
                acc_full_d   = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data_q   <= '0;
            acc_keep_q   <= '0;
            cnt_q        <= '0;
            acc_full_q   <= 1'b0;
            spare_data_q <= '0;
            spare_keep_q <= '0;
            spare_last_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_keep_q   <= acc_keep_d;
            cnt_q        <= cnt_d;
            acc_full_q   <= acc_full_d;
            spare_data_q <= spare_data_d;
            spare_keep_q <= spare_keep_d;
            spare_last_q <= spare_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (IN_WIDTH=8, RATIO=4): directed vector table,
// hand-written reset sequences, and a randomized scoreboard run.
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    stream_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic r,
                                input logic e_ir, input logic e_ov, input logic [31:0] e_data,
                                input logic [3:0] e_keep, input logic e_last);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.r = r;
        x.e_ir = e_ir; x.e_ov = e_ov; x.e_data = e_data; x.e_keep = e_keep; x.e_last = e_last;
        return x;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    vec_t  tbl[$];
    word_t exp_q[$];
    word_t got;
    word_t exp_w;
    word_t prev_out;
    logic [31:0] m_d;
    logic [3:0]  m_k;
    int          m_cnt;
    int          acc_beats;
    bit          done;
    bit          stall_prev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Continuous stream and short/single-beat packets
        tbl.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0));
        tbl.push_back(mk(1, 8'h55, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h66, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h77, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h88, 1, 1, 1, 1, 32'h88776655, 4'hF, 1));
        tbl.push_back(mk(1, 8'hA1, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'hB2, 1, 1, 1, 1, 32'h0000B2A1, 4'h3, 1));
        tbl.push_back(mk(1, 8'h5C, 1, 1, 1, 1, 32'h0000005C, 4'h1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        // Backpressure: 12 beats with out_ready low, then release
        tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h04, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h06, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h07, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 0, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h09, 1, 0, 0, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(mk(1, 8'h09, 0, 1, 1, 1, 32'h08070605, 4'hF, 0));
        tbl.push_back(mk(1, 8'h09, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h0A, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h0B, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        tbl.push_back(mk(1, 8'h0C, 0, 1, 1, 1, 32'h0C0B0A09, 4'hF, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0));

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_out_keep",  32'(out_keep),  32'h0);
        chk("rst_out_last",  32'(out_last),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data,      tbl[i].e_data);
                chk($sformatf("vec%0d_out_keep", i), 32'(out_keep), 32'(tbl[i].e_keep));
                chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
            end
        end

        // Reset mid-packet with a stalled output word and a partial accumulator
        step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
        chk("mrst_pre_valid", 32'(out_valid), 32'h1);
        step(1, 8'hEE, 0, 0); step(1, 8'hFF, 0, 0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_out_keep",  32'(out_keep),  32'h0);
        chk("mrst_in_ready",  32'(in_ready),  32'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("mrst_in_ready_after", 32'(in_ready), 32'h1);
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1);
        chk("mrst_no_stale_word", 32'(out_valid), 32'h0);
        step(1, 8'h04, 0, 1);
        chk("mrst_word_valid", 32'(out_valid), 32'h1);
        chk("mrst_word_data",  out_data,       32'h04030201);
        chk("mrst_word_keep",  32'(out_keep),  32'hF);
        chk("mrst_word_last",  32'(out_last),  32'h0);
        step(0, 8'h00, 0, 1);
        chk("mrst_drained", 32'(out_valid), 32'h0);

        // Randomized traffic against a reference packer model
        m_d = '0; m_k = '0; m_cnt = 0; acc_beats = 0; done = 0; stall_prev = 0; prev_out = '0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_last   = (acc_beats >= 1000) ? 1'b1 : ($urandom_range(0, 7) == 0);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            got = {out_data, out_keep, out_last};
            if (stall_prev) begin
                chk("rand_hold_valid", 32'(out_valid), 32'h1);
                chk("rand_hold_word",  32'(got != prev_out), 32'h0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_word", 32'h1, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("rand_data", out_data,      exp_w.d);
                    chk("rand_keep", 32'(out_keep), 32'(exp_w.k));
                    chk("rand_last", 32'(out_last), 32'(exp_w.l));
                end
            end
            if (in_valid && in_ready) begin
                m_d[m_cnt*8 +: 8] = in_data;
                m_k[m_cnt]        = 1'b1;
                if (in_last || m_cnt == 3) begin
                    exp_q.push_back({m_d, m_k, in_last});
                    m_d = '0; m_k = '0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
                if (acc_beats >= 1000) done = 1;
                acc_beats++;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = got;
            @(posedge clk);
        end
        if (!done) chk("rand_timeout", 32'h1, 32'h0);

        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_extra_word", 32'h1, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("drain_data", out_data,      exp_w.d);
                    chk("drain_keep", 32'(out_keep), 32'(exp_w.k));
                    chk("drain_last", 32'(out_last), 32'(exp_w.l));
                end
            end
            @(posedge clk);
        end
        chk("rand_words_left", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
